// File: rtl/demux_1to4.sv
// demux_1to4: registered 1-to-4 demux with valid/ready per channel.
// Ports: clk, rst_n (sync, active-low); in_data/S1/S0/in_valid/in_ready
// from the producer; A..D, out_valid[3:0], out_ready[3:0] per channel
// (bit0=A .. bit3=D); xfer_count only when DEMUX_CNT_EN is defined.
module demux_1to4 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             S1,
   input  logic             S0,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] D,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready
`ifdef DEMUX_CNT_EN
   ,
   output logic [15:0]      xfer_count
`endif
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } ch_state_e;

   ch_state_e        state_q [4];
   ch_state_e        state_d [4];
   logic [WIDTH-1:0] data_q  [4];
   logic [WIDTH-1:0] data_d  [4];

   logic [1:0] sel;
   logic [3:0] sel_oh;
   logic [3:0] full;
   logic [3:0] load;
   logic       accept;

   assign sel = {S1, S0};

   always_comb begin
      sel_oh = 4'b0000;
      unique case (sel)
         2'd0: sel_oh = 4'b0001;
         2'd1: sel_oh = 4'b0010;
         2'd2: sel_oh = 4'b0100;
         2'd3: sel_oh = 4'b1000;
         default: sel_oh = 4'b0000;
      endcase
   end

   // Ready looks only at the addressed channel, so a stalled
   // consumer blocks just the words heading to it.
   assign in_ready = ~full[sel] | out_ready[sel];
   assign accept   = in_valid & in_ready;
   assign load     = accept ? sel_oh : 4'b0000;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= EMPTY;
            data_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= state_d[i];
            data_q[i]  <= data_d[i];
         end
      end
   end

   // Next-state logic; accept+drain on a full channel stays FULL
   // with the new word replacing the old one.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         state_d[i] = state_q[i];
         data_d[i]  = data_q[i];
         unique case (state_q[i])
            EMPTY: begin
               if (load[i]) state_d[i] = FULL;
            end
            FULL: begin
               if (!load[i] && out_ready[i])
                  state_d[i] = EMPTY;
            end
            default: state_d[i] = EMPTY;
         endcase
         if (load[i]) data_d[i] = in_data;
      end
   end

   // Output logic
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         full[i] = (state_q[i] == FULL);
      end
      out_valid = full;
      A = data_q[0];
      B = data_q[1];
      C = data_q[2];
      D = data_q[3];
   end

`ifdef DEMUX_CNT_EN
   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (accept) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign xfer_count = cnt_q;
`endif

endmodule
